// File: rtl/pipe_ctrl.sv
// Stall/flush scheduler for the F/D/E/M/W pipeline: memory-wait, divide-wait,
// load-use bubbles, taken-branch squash and exception flush.
module pipe_ctrl #(
    parameter int DIV_LAT = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       load_useD,
    input  logic       div_startE,
    input  logic       br_takenD,
    input  logic       mem_reqM,
    input  logic       data_ok,
    input  logic       excW,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushD,
    output logic       flushE,
    output logic       flushM,
    output logic       div_go,
    output logic       div_cancel,
    output logic [1:0] state
);
    localparam int CW = $clog2(DIV_LAT);

    typedef enum logic [1:0] {RUN = 2'd0, MEMW = 2'd1, DIVW = 2'd2} state_t;

    state_t          cur, nxt;
    logic [CW-1:0]   cnt, cntNxt;
    logic            discard, discardNxt;
    logic            memBusy;

    assign state = cur;

    // A response that arrives while discard is set belongs to a squashed
    // request, so it never counts as completion of the current one.
    assign memBusy = (cur != DIVW) && ((cur == MEMW) || mem_reqM) && (!data_ok || discard);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cur     <= RUN;
            cnt     <= '0;
            discard <= 1'b0;
        end else begin
            cur     <= nxt;
            cnt     <= cntNxt;
            discard <= discardNxt;
        end
    end

    always_comb begin
        nxt        = cur;
        cntNxt     = cnt;
        discardNxt = discard;
        stallF     = 1'b0;
        stallD     = 1'b0;
        stallE     = 1'b0;
        stallM     = 1'b0;
        flushD     = 1'b0;
        flushE     = 1'b0;
        flushM     = 1'b0;
        div_go     = 1'b0;
        div_cancel = 1'b0;

        if (discard && data_ok)
            discardNxt = 1'b0;

        if (!resetn) begin
            flushD     = 1'b1;
            flushE     = 1'b1;
            flushM     = 1'b1;
            nxt        = RUN;
            cntNxt     = '0;
            discardNxt = 1'b0;
        end else if (excW) begin
            flushD     = 1'b1;
            flushE     = 1'b1;
            flushM     = 1'b1;
            nxt        = RUN;
            cntNxt     = '0;
            div_cancel = (cur == DIVW);
            if ((cur == MEMW) || (mem_reqM && !data_ok))
                discardNxt = 1'b1;
        end else if (memBusy) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            nxt    = MEMW;
        end else if (cur == MEMW) begin
            nxt = RUN;
        end else if (cur == DIVW) begin
            if (cnt != '0) begin
                stallF = 1'b1;
                stallD = 1'b1;
                stallE = 1'b1;
                flushM = 1'b1;
                cntNxt = cnt - CW'(1);
            end else begin
                nxt = RUN;
            end
        end else if (div_startE) begin
            div_go = 1'b1;
            cntNxt = CW'(DIV_LAT - 1);
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            flushM = 1'b1;
            nxt    = DIVW;
        end else if (load_useD) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end

        // A held D stage keeps the branch, so its squash waits until D moves.
        if (resetn && !excW && br_takenD && !stallD)
            flushD = 1'b1;
    end
endmodule
